noc_router_buffered: RTL and testbench
======================================

# noc_router_buffered

Next-generation 5-port mesh router for the neuromorphic NoC, replacing the unbuffered combinational-crossbar router in each tile. Adds a per-input flit FIFO, a registered output stage and true round-robin arbitration. Header field widths, FIFO depth and data width are parametrised. It routes spike flits deterministically with XY routing between the tile's local core (port 0) and its four mesh neighbours.

## Interface
- DATA_WIDTH, 32: flit width in bits; must be ≥ 2*COORD_W.
- COORD_W, 8: width of each destination coordinate field.
- ADDR_X, 0: this router's X coordinate (unsigned).
- ADDR_Y, 0: this router's Y coordinate (unsigned).
- FIFO_DEPTH, 4: entries per input FIFO; power of two, ≥ 2.

Port index p: 0 Local, 1 North, 2 East, 3 South, 4 West. Bus slice for port p is [p*DATA_WIDTH +: DATA_WIDTH] for data and bit [p] for control.

- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- din  in  5*DATA_WIDTH  input flits.
- vin  in  5  input valid.
- rout  out  5  input ready; a flit transfers on an edge where vin[p]&rout[p].
- dout  out  5*DATA_WIDTH  output flits, registered.
- vout  out  5  output valid, registered.
- rin  in  5  downstream ready; a flit leaves on an edge where vout[p]&rin[p].

## Operation
- Header: dest_x = flit[DATA_WIDTH-1 -: COORD_W], dest_y = flit[DATA_WIDTH-1-COORD_W -: COORD_W]. Payload is passed through untouched.
- Route is computed on each FIFO head:
  - dest_x<ADDR_X → 4 (West); dest_x>ADDR_X → 2 (East).
  - Otherwise dest_y<ADDR_Y → 1 (North); dest_y>ADDR_Y → 3 (South).
  - Otherwise → 0 (Local).
  - Compares are unsigned. U-turns are not filtered.
- Input FIFO per port:
  - rout[p] = ~full[p], derived from the registered count only.
  - When full, a same-cycle pop does not enable a push.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Flits leave in arrival order.
- Output register per port:
  - can_load[o] = ~vout[o] | rin[o].
  - On load, dout[o]/vout[o] take the granted head. If can_load[o] and nothing is granted, vout[o] goes to 0.
  - While vout[o]&~rin[o], dout[o] and vout[o] hold stable.
- Arbitration per output o:
  - Requesters are non-empty inputs whose head routes to o.
  - Search starts at rr_ptr[o], ascending modulo 5; the first requester wins only if can_load[o].
  - On a grant to input i, the head of i pops and rr_ptr[o] ← (i+1) mod 5. With no grant, rr_ptr[o] holds.
  - Each head targets exactly one output, so an input is popped at most once per cycle. All five outputs may grant in the same cycle.
- No flit is dropped, duplicated or reordered per input→output pair.

## Timing
- Reset (async, immediate):
  - All FIFOs empty; rr_ptr = 0.
  - vout = 0, dout = 0.
  - rout = 5'b11111, but vin is ignored while rst is high.
- Latency: a flit pushed into an empty FIFO on edge E, with its output free, loads the output register on edge E+1, so vout is high in the cycle after E+1. Minimum latency is two edges.
- Throughput: one flit per output per cycle under sustained rin = 1.
- Buffering per input→output path: FIFO_DEPTH + 1 flits (FIFO plus output register) before rout drops, when the output is stalled.
- Reset mid-operation discards all buffered flits and the output registers. After release, no stale flit appears.

## Test plan
Defaults throughout, with ADDR_X=1, ADDR_Y=1.

- Single route: din[0]=0x0201ABCD (dest 2,1), vin[0] one cycle, rin=all 1 → vout[2]=1 with dout[2]=0x0201ABCD exactly two edges after the push, for one cycle; all other vout stay 0.
- Round-robin contention: inputs 1, 3, 4 each push 0x0101000n (local) on the same edge, rin[0]=1 → port 0 emits the input-1, input-3, input-4 flits on three consecutive cycles; rr_ptr[0] ends at 0. A repeat with inputs 0 and 1 then emits input 0 first.
- Backpressure: rin[2]=0, local pushes 0x02010001…0x02010006 back-to-back → rout[0] falls after the 5th accept; dout[2]=0x02010001 holds stable. Raising rin[2] delivers all 6 in order, with the 6th accepted once space frees.
- Parallel switching: on one edge push local→(2,1), north→(1,2), east→(0,1), south→(1,0), west→(1,1), rin=all 1 → vout=5'b11111 in the same cycle with the correct flit on each port.
- Full boundary: fill FIFO 3 (4 flits stalled plus 1 in output register), hold vin[3]=1 → no extra flit is accepted; after one rin pulse exactly one more flit is accepted.
- Reset mid-traffic: with 3 flits buffered, pulse rst asynchronously between edges → vout and dout go to 0 immediately; after release, no flits emerge and rout=5'b11111.

Source files
------------

// File: rtl/noc_router_buffered.sv
// noc_router_buffered
// 5-port XY mesh router with one flit FIFO per input, a registered output
// stage per output and round-robin arbitration on each output.
// Port index: 0 Local, 1 North, 2 East, 3 South, 4 West.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-high reset
//   din  - 5 input flits, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   vin  - input valid per port
//   rout - input ready per port (FIFO not full)
//   dout - 5 registered output flits
//   vout - registered output valid per port
//   rin  - downstream ready per port
module noc_router_buffered #(
    parameter int DATA_WIDTH = 32,
    parameter int COORD_W    = 8,
    parameter int ADDR_X     = 0,
    parameter int ADDR_Y     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5*DATA_WIDTH-1:0] din,
    input  logic [4:0]              vin,
    output logic [4:0]              rout,
    output logic [5*DATA_WIDTH-1:0] dout,
    output logic [4:0]              vout,
    input  logic [4:0]              rin
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [COORD_W-1:0] MY_X     = COORD_W'(ADDR_X);
    localparam logic [COORD_W-1:0] MY_Y     = COORD_W'(ADDR_Y);
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(FIFO_DEPTH);

    // XY route of a header: resolve X first, then Y, else deliver locally.
    function automatic logic [2:0] route_of(input logic [2*COORD_W-1:0] hdr);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        dx = hdr[2*COORD_W-1 -: COORD_W];
        dy = hdr[COORD_W-1:0];
        if (dx < MY_X)      return 3'd4;
        else if (dx > MY_X) return 3'd2;
        else if (dy < MY_Y) return 3'd1;
        else if (dy > MY_Y) return 3'd3;
        else                return 3'd0;
    endfunction

    // Round-robin pick: first set bit of req at or after ptr, modulo 5.
    // Result is {found, index}. Scanning downward lets the nearest win.
    function automatic logic [3:0] rr_pick(input logic [4:0] req, input logic [2:0] ptr);
        logic [3:0] pick;
        logic [3:0] pos;
        pick = 4'd0;
        for (int k = 4; k >= 0; k--) begin
            pos = {1'b0, ptr} + 4'(k);
            if (pos >= 4'd5) pos = pos - 4'd5;
            if (req[pos[2:0]]) pick = {1'b1, pos[2:0]};
        end
        return pick;
    endfunction

    logic [DATA_WIDTH-1:0] r_mem  [5][FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr [5];
    logic [PTR_W-1:0]      r_rptr [5];
    logic [CNT_W-1:0]      r_cnt  [5];
    logic [2:0]            r_rr   [5];
    logic [DATA_WIDTH-1:0] r_dout [5];
    logic [4:0]            r_vout;

    logic [4:0]            w_full;
    logic [4:0]            w_empty;
    logic [4:0]            w_push;
    logic [4:0]            w_pop;
    logic [4:0]            w_can_load;
    logic [4:0]            w_gnt;
    logic [DATA_WIDTH-1:0] w_head    [5];
    logic [2:0]            w_route   [5];
    logic [4:0]            w_req     [5];
    logic [3:0]            w_pick    [5];
    logic [2:0]            w_gnt_idx [5];

    // Fullness comes from the registered count only, so a pop in the same
    // cycle never opens a slot for a push into a full FIFO.
    always_comb begin
        for (int p = 0; p < 5; p++) begin
            w_full[p]  = (r_cnt[p] == FULL_CNT);
            w_empty[p] = (r_cnt[p] == '0);
            w_push[p]  = vin[p] & ~w_full[p];
            w_head[p]  = r_mem[p][r_rptr[p]];
            w_route[p] = route_of(w_head[p][DATA_WIDTH-1 -: 2*COORD_W]);
        end
    end

    // Each head requests exactly one output, so at most one grant pops it.
    always_comb begin
        w_pop = '0;
        for (int o = 0; o < 5; o++) begin
            w_can_load[o] = ~r_vout[o] | rin[o];
            for (int i = 0; i < 5; i++) begin
                w_req[o][i] = ~w_empty[i] & (w_route[i] == 3'(o));
            end
            w_pick[o]    = rr_pick(w_req[o], r_rr[o]);
            w_gnt[o]     = w_pick[o][3] & w_can_load[o];
            w_gnt_idx[o] = w_pick[o][2:0];
        end
        for (int o = 0; o < 5; o++) begin
            for (int i = 0; i < 5; i++) begin
                if (w_gnt[o] && (w_gnt_idx[o] == 3'(i))) w_pop[i] = 1'b1;
            end
        end
    end

    // FIFO storage carries no reset; validity is tracked by the counters.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 5; p++) begin
            if (w_push[p]) r_mem[p][r_wptr[p]] <= din[p*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 5; p++) begin
                r_wptr[p] <= '0;
                r_rptr[p] <= '0;
                r_cnt[p]  <= '0;
                r_rr[p]   <= 3'd0;
                r_dout[p] <= '0;
            end
            r_vout <= '0;
        end else begin
            for (int p = 0; p < 5; p++) begin
                if (w_push[p]) r_wptr[p] <= r_wptr[p] + PTR_W'(1);
                if (w_pop[p])  r_rptr[p] <= r_rptr[p] + PTR_W'(1);
                r_cnt[p] <= r_cnt[p] + CNT_W'(w_push[p]) - CNT_W'(w_pop[p]);
            end
            for (int o = 0; o < 5; o++) begin
                if (w_can_load[o]) begin
                    r_vout[o] <= w_gnt[o];
                    if (w_gnt[o]) begin
                        r_dout[o] <= w_head[w_gnt_idx[o]];
                        r_rr[o]   <= (w_gnt_idx[o] == 3'd4) ? 3'd0 : w_gnt_idx[o] + 3'd1;
                    end
                end
            end
        end
    end

    assign rout = ~w_full;
    assign vout = r_vout;

    always_comb begin
        for (int o = 0; o < 5; o++) begin
            dout[o*DATA_WIDTH +: DATA_WIDTH] = r_dout[o];
        end
    end

endmodule

// File: tb/tb_noc_router_buffered.sv
// Bench for noc_router_buffered at ADDR_X=1, ADDR_Y=1 with default widths.
module tb_noc_router_buffered;
    logic         clk = 1'b0;
    logic         rst;
    logic [159:0] din;
    logic [4:0]   vin;
    logic [4:0]   rout;
    logic [159:0] dout;
    logic [4:0]   vout;
    logic [4:0]   rin;

    int total = 0;
    int bad   = 0;

    int           got, acc, seqv, expn, remaining, s, qi;
    logic         a;
    logic [4:0]   orv;
    logic [4:0]   prev_stall;
    logic [31:0]  prev_d [5];
    logic [31:0]  f;
    int           seqn [5];
    logic [31:0]  sbq [25][$];

    always #5 clk = ~clk;

    noc_router_buffered #(
        .DATA_WIDTH(32), .COORD_W(8), .ADDR_X(1), .ADDR_Y(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .vin(vin), .rout(rout),
        .dout(dout), .vout(vout), .rin(rin)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setd(input int p, input logic [31:0] v);
        din[p*32 +: 32] = v;
    endtask

    function automatic logic [31:0] slice(input logic [159:0] v, input int p);
        return v[p*32 +: 32];
    endfunction

    // Destination port from the header by the XY rules at router (1,1).
    function automatic int ref_route(input logic [31:0] fl);
        int dx, dy;
        dx = int'(fl[31:24]);
        dy = int'(fl[23:16]);
        if (dx < 1) return 4;
        if (dx > 1) return 2;
        if (dy < 1) return 1;
        if (dy > 1) return 3;
        return 0;
    endfunction

    function automatic logic [31:0] mk_flit(input int p, input int sq);
        logic [7:0] dx, dy;
        dx = 8'($urandom_range(0, 2));
        dy = 8'($urandom_range(0, 2));
        return {dx, dy, 3'(p), 13'(sq)};
    endfunction

    initial begin
        rst = 1'b0; din = '0; vin = '0; rin = '1;
        prev_stall = '0;
        for (int p = 0; p < 5; p++) begin seqn[p] = 0; prev_d[p] = '0; end
        #1 rst = 1'b1;
        #1;
        chk("reset_vout", 160'(vout), 160'(0));
        chk("reset_dout", dout, 160'(0));
        chk("reset_rout", 160'(rout), 160'(5'h1f));
        tick(); tick();
        rst = 1'b0;
        tick();

        // single route to East
        setd(0, 32'h0201ABCD); vin = 5'b00001;
        tick(); vin = '0;
        chk("single_e1_vout", 160'(vout), 160'(0));
        tick();
        chk("single_e2_vout", 160'(vout), 160'(5'b00100));
        chk("single_e2_dout", 160'(slice(dout, 2)), 160'(32'h0201ABCD));
        tick();
        chk("single_e3_vout", 160'(vout), 160'(0));

        // round-robin contention on Local
        setd(1, 32'h01010001); setd(3, 32'h01010003); setd(4, 32'h01010004);
        vin = 5'b11010;
        tick(); vin = '0;
        tick();
        chk("rr_first_vout", 160'(vout), 160'(5'b00001));
        chk("rr_first_dout", 160'(slice(dout, 0)), 160'(32'h01010001));
        tick();
        chk("rr_second_dout", 160'(slice(dout, 0)), 160'(32'h01010003));
        tick();
        chk("rr_third_dout", 160'(slice(dout, 0)), 160'(32'h01010004));
        tick();
        chk("rr_idle_vout", 160'(vout), 160'(0));
        setd(0, 32'h01010000); setd(1, 32'h01010001); vin = 5'b00011;
        tick(); vin = '0;
        tick();
        chk("rr_wrap_first_dout", 160'(slice(dout, 0)), 160'(32'h01010000));
        chk("rr_wrap_first_vout", 160'(vout), 160'(5'b00001));
        tick();
        chk("rr_wrap_second_dout", 160'(slice(dout, 0)), 160'(32'h01010001));
        tick();
        chk("rr_wrap_idle_vout", 160'(vout), 160'(0));

        // backpressure on East
        rin = 5'b11011;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("bp_rout_before_%0d", k), 160'(rout[0]), 160'(1));
            setd(0, 32'h02010000 + 32'(k)); vin = 5'b00001;
            tick();
        end
        setd(0, 32'h02010006);
        chk("bp_rout_full", 160'(rout[0]), 160'(0));
        chk("bp_vout_held", 160'(vout[2]), 160'(1));
        chk("bp_dout_held", 160'(slice(dout, 2)), 160'(32'h02010001));
        tick(); tick();
        chk("bp_rout_still_full", 160'(rout[0]), 160'(0));
        chk("bp_dout_stable", 160'(slice(dout, 2)), 160'(32'h02010001));
        rin = 5'b11111;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (vout[2]) begin
                chk($sformatf("bp_order_%0d", got + 1), 160'(slice(dout, 2)), 160'(32'h02010001 + 32'(got)));
                got++;
            end
            a = vin[0] & rout[0];
            tick();
            if (a) vin[0] = 1'b0;
        end
        chk("bp_count", 160'(got), 160'(6));

        // parallel switching, all five outputs at once
        setd(0, 32'h02010010); setd(1, 32'h01020011); setd(2, 32'h00010012);
        setd(3, 32'h01000013); setd(4, 32'h01010014);
        vin = 5'h1f;
        tick(); vin = '0;
        tick();
        chk("par_vout", 160'(vout), 160'(5'h1f));
        chk("par_dout", dout, {32'h00010012, 32'h01020011, 32'h02010010, 32'h01000013, 32'h01010014});
        tick();
        chk("par_idle_vout", 160'(vout), 160'(0));

        // full boundary on input 3 routed to a stalled North output
        rin = 5'b11101;
        seqv = 1; acc = 0;
        vin = 5'b01000; setd(3, 32'h01000000 + 32'(seqv));
        for (int c = 0; c < 10; c++) begin
            a = vin[3] & rout[3];
            tick();
            if (a) begin acc++; seqv++; setd(3, 32'h01000000 + 32'(seqv)); end
        end
        chk("full_accepts", 160'(acc), 160'(5));
        chk("full_rout", 160'(rout[3]), 160'(0));
        chk("full_vout", 160'(vout[1]), 160'(1));
        chk("full_dout", 160'(slice(dout, 1)), 160'(32'h01000001));
        rin[1] = 1'b1;
        a = vin[3] & rout[3];
        chk("full_pulse_no_accept", 160'(a), 160'(0));
        tick();
        rin[1] = 1'b0;
        chk("full_after_pulse_dout", 160'(slice(dout, 1)), 160'(32'h01000002));
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            a = vin[3] & rout[3];
            tick();
            if (a) begin acc++; seqv++; setd(3, 32'h01000000 + 32'(seqv)); end
        end
        chk("full_extra_accept", 160'(acc), 160'(1));
        vin = '0; rin[1] = 1'b1;
        expn = 2;
        for (int c = 0; c < 12; c++) begin
            if (vout[1]) begin
                chk($sformatf("full_drain_%0d", expn), 160'(slice(dout, 1)), 160'(32'h01000000 + 32'(expn)));
                expn++;
            end
            tick();
        end
        chk("full_drain_count", 160'(expn), 160'(7));

        // reset in the middle of traffic
        rin = 5'b11011;
        for (int k = 1; k <= 3; k++) begin
            setd(0, 32'h02010020 + 32'(k)); vin = 5'b00001;
            tick();
        end
        vin = '0;
        tick();
        chk("mid_pre_vout", 160'(vout[2]), 160'(1));
        #3;
        rst = 1'b1;
        for (int p = 0; p < 5; p++) setd(p, 32'h01010099);
        vin = 5'h1f;
        #1;
        chk("mid_rst_vout", 160'(vout), 160'(0));
        chk("mid_rst_dout", dout, 160'(0));
        chk("mid_rst_rout", 160'(rout), 160'(5'h1f));
        @(posedge clk);
        #3;
        vin = '0;
        rst = 1'b0;
        rin = '1;
        tick();
        orv = '0;
        for (int c = 0; c < 6; c++) begin
            orv = orv | vout;
            tick();
        end
        chk("mid_no_stale", 160'(orv), 160'(0));
        chk("mid_rout_after", 160'(rout), 160'(5'h1f));

        // randomized traffic against a per input/output scoreboard
        for (int c = 0; c < 1000; c++) begin
            for (int o = 0; o < 5; o++) begin
                if (prev_stall[o]) begin
                    chk($sformatf("rnd_hold_vout_%0d", o), 160'(vout[o]), 160'(1));
                    chk($sformatf("rnd_hold_dout_%0d", o), 160'(slice(dout, o)), 160'(prev_d[o]));
                end
            end
            if (c < 960) begin
                for (int o = 0; o < 5; o++) rin[o] = ($urandom_range(0, 3) != 0);
                for (int p = 0; p < 5; p++) begin
                    vin[p] = ($urandom_range(0, 1) == 1);
                    setd(p, mk_flit(p, seqn[p]));
                end
            end else begin
                rin = '1;
                vin = '0;
            end
            for (int o = 0; o < 5; o++) begin
                if (vout[o] && rin[o]) begin
                    f = slice(dout, o);
                    s = int'(f[15:13]);
                    if (s > 4) begin
                        chk($sformatf("rnd_src_o%0d", o), 160'(f[15:13]), 160'(0));
                    end else begin
                        qi = s * 5 + o;
                        if (sbq[qi].size() == 0) begin
                            chk($sformatf("rnd_expected_o%0d", o), 160'(0), 160'(1));
                        end else begin
                            chk($sformatf("rnd_data_i%0d_o%0d", s, o), 160'(f), 160'(sbq[qi].pop_front()));
                        end
                    end
                end
            end
            for (int p = 0; p < 5; p++) begin
                if (vin[p] && rout[p]) begin
                    f = slice(din, p);
                    sbq[p * 5 + ref_route(f)].push_back(f);
                    seqn[p]++;
                end
            end
            prev_stall = vout & ~rin;
            for (int o = 0; o < 5; o++) prev_d[o] = slice(dout, o);
            tick();
        end
        remaining = 0;
        for (int q = 0; q < 25; q++) remaining += sbq[q].size();
        chk("rnd_leftover", 160'(remaining), 160'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
